shadow_copy: RTL and testbench

Write-shadow copy engine between the CPU bus and the 128 KB slow RAM (banks E0/E1). Snoops CPU writes to banks 00/01 that fall in a shadowed display region, queues them in a small FIFO, and replays them into slow RAM at the 1 MHz slot rate. Stalls the CPU through `cpu_wait` when the queue is full, so fast-RAM writes are never lost from the video copy.

---
 rtl/iigs_pkg.sv | 45 ++++
 rtl/shadow_fifo.sv | 73 +++++++
 rtl/shadow_copy.sv | 120 ++++++++++++
 tb/tb_shadow_copy.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iigs_pkg.sv
// Shared Apple IIgs definitions for the shadow copy engine: SHADOW register
// bit positions, shadowed display region bounds, FIFO entry layout and the
// drain state encoding.
package iigs_pkg;

    // SHADOW register bit positions (a 0 bit enables shadowing)
    localparam int TXT1 = 0;
    localparam int HGR1 = 1;
    localparam int HGR2 = 2;
    localparam int SHR  = 3;
    localparam int AUX  = 4;
    localparam int TXT2 = 5;
    localparam int IOLC = 6;

    // Shadowed display regions inside banks 00/01
    localparam logic [15:0] TXT1_BASE    = 16'h0400;
    localparam logic [15:0] TXT1_LIMIT   = 16'h07FF;
    localparam logic [15:0] TXT2_BASE    = 16'h0800;
    localparam logic [15:0] TXT2_LIMIT   = 16'h0BFF;
    localparam logic [15:0] HGR1_BASE    = 16'h2000;
    localparam logic [15:0] HGR1_LIMIT   = 16'h3FFF;
    localparam logic [15:0] HGR2_BASE    = 16'h4000;
    localparam logic [15:0] HGR2_LIMIT   = 16'h5FFF;
    localparam logic [15:0] SHR_HI_BASE  = 16'h6000;
    localparam logic [15:0] SHR_HI_LIMIT = 16'h9FFF;

    // One queued write: 17-bit slow-RAM address {bank[0], addr} and data
    typedef struct packed {
        logic [16:0] a17;
        logic [7:0]  d8;
    } shadow_entry_t;

    // Drain FSM: WRITE lasts exactly one cycle per popped entry
    typedef enum logic {
        DRAIN_IDLE  = 1'b0,
        DRAIN_WRITE = 1'b1
    } drain_state_t;

    function automatic logic in_region(input logic [15:0] a,
                                       input logic [15:0] base,
                                       input logic [15:0] limit);
        return (a >= base) && (a <= limit);
    endfunction

endpackage

// File: rtl/shadow_fifo.sv
// Synchronous FIFO holding snooped CPU writes until a slow-RAM slot is free.
// A push while full is accepted only when a pop happens in the same cycle;
// the popped head slot is the one the push overwrites.
module shadow_fifo
    import iigs_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  shadow_entry_t            din,
    output shadow_entry_t            head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    shadow_entry_t   mem_q [DEPTH];
    shadow_entry_t   mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            do_push;
    logic            do_pop;

    assign full  = (level_q == FULL_LEVEL);
    assign empty = (level_q == '0);
    assign level = level_q;
    assign head  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            level_d = level_q + LW'(1);
        end else if (do_pop && !do_push) begin
            level_d = level_q - LW'(1);
        end
    end

    // Register FIFO state; reset empties the queue without clearing storage
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/shadow_copy.sv
// Write-shadow copy engine: snoops CPU writes to banks 00/01 in shadowed
// display regions, queues them, and replays them into slow RAM (E0/E1) once
// per slot. Define SHADOW_SHR_EN to shadow the full Super Hi-Res range
// 2000-9FFF; without it SHADOW bit 3 is treated as set everywhere.
module shadow_copy
    import iigs_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int SLOT_PERIOD = 14
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     fast_clk,
    input  logic [7:0]               bank,
    input  logic [15:0]              addr,
    input  logic [7:0]               dout,
    input  logic                     we,
    input  logic                     IO,
    input  logic [7:0]               shadow,
    input  logic                     slow_busy,
    output logic [16:0]              slow_addr,
    output logic [7:0]               slow_data,
    output logic                     slow_we,
    output logic                     cpu_wait,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int CW = $clog2(SLOT_PERIOD);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_PERIOD - 1);

    logic            is_bank00, is_bank01, aux_ok, shr_all;
    logic            hit_txt1, hit_txt2, hit_hgr1, hit_hgr2, hit_shr_hi;
    logic            hit, pop_req;
    shadow_entry_t   push_entry, fifo_head;
    logic            fifo_full, fifo_empty;
    logic            unused_shadow_bits;

    logic [CW-1:0]   slot_q, slot_d;
    drain_state_t    state_q, state_d;
    logic [16:0]     slow_addr_q, slow_addr_d;
    logic [7:0]      slow_data_q, slow_data_d;
    logic            overflow_q, overflow_d;

`ifdef SHADOW_SHR_EN
    assign unused_shadow_bits = ^shadow[IOLC+1:IOLC];
`else
    assign unused_shadow_bits = ^{shadow[IOLC+1:IOLC], shadow[SHR]};
`endif

    // Decide whether the current CPU bus cycle is a shadowed write
    always_comb begin
        is_bank00 = (bank == 8'h00);
        is_bank01 = (bank == 8'h01);
        aux_ok    = is_bank00 | ~shadow[AUX];
`ifdef SHADOW_SHR_EN
        shr_all    = ~shadow[SHR];
        hit_shr_hi = is_bank01 & in_region(addr, SHR_HI_BASE, SHR_HI_LIMIT) & ~shadow[SHR];
`else
        shr_all    = 1'b0;
        hit_shr_hi = 1'b0;
`endif
        hit_txt1 = in_region(addr, TXT1_BASE, TXT1_LIMIT) & ~shadow[TXT1] & aux_ok;
        hit_txt2 = in_region(addr, TXT2_BASE, TXT2_LIMIT) & ~shadow[TXT2] & aux_ok;
        hit_hgr1 = in_region(addr, HGR1_BASE, HGR1_LIMIT) & ((~shadow[HGR1] & aux_ok) | shr_all);
        hit_hgr2 = in_region(addr, HGR2_BASE, HGR2_LIMIT) & ((~shadow[HGR2] & aux_ok) | shr_all);
        hit      = fast_clk & we & ~IO & (is_bank00 | is_bank01)
                 & (hit_txt1 | hit_txt2 | hit_hgr1 | hit_hgr2 | hit_shr_hi);
        push_entry.a17 = {bank[0], addr};
        push_entry.d8  = dout;
    end

    shadow_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .push    (hit),
        .pop     (pop_req),
        .din     (push_entry),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    // Slot timer, drain decision and sticky overflow next-state
    always_comb begin
        pop_req     = (slot_q == '0) & ~fifo_empty & ~slow_busy;
        slot_d      = (slot_q == SLOT_LAST) ? '0 : slot_q + CW'(1);
        state_d     = pop_req ? DRAIN_WRITE : DRAIN_IDLE;
        slow_addr_d = pop_req ? fifo_head.a17 : slow_addr_q;
        slow_data_d = pop_req ? fifo_head.d8  : slow_data_q;
        overflow_d  = overflow_q | (hit & fifo_full & ~pop_req);
    end

    // Register the drain FSM and every slow-RAM facing output
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            slot_q      <= '0;
            state_q     <= DRAIN_IDLE;
            slow_addr_q <= '0;
            slow_data_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            state_q     <= state_d;
            slow_addr_q <= slow_addr_d;
            slow_data_q <= slow_data_d;
            overflow_q  <= overflow_d;
        end
    end

    assign slow_addr = slow_addr_q;
    assign slow_data = slow_data_q;
    assign slow_we   = (state_q == DRAIN_WRITE);
    assign cpu_wait  = fifo_full;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_shadow_copy.sv
// Directed bench for shadow_copy (DEPTH=4, SLOT_PERIOD=14). Slot boundaries
// are tracked by counting clock edges since reset was released: the edge
// numbered 1 + 14*k samples slot count 0.
module tb_shadow_copy;

`ifdef SHADOW_SHR_EN
    localparam bit SHR_BUILD = 1'b1;
`else
    localparam bit SHR_BUILD = 1'b0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        fast_clk = 1'b0;
    logic [7:0]  bank = 8'h00;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  dout = 8'h00;
    logic        we = 1'b0;
    logic        IO = 1'b0;
    logic [7:0]  shadow = 8'hFF;
    logic        slow_busy = 1'b0;
    logic [16:0] slow_addr;
    logic [7:0]  slow_data;
    logic        slow_we;
    logic        cpu_wait;
    logic [2:0]  level;
    logic        overflow;

    int checks = 0;
    int failures = 0;
    int ecount = 0;

    shadow_copy #(.DEPTH(4), .SLOT_PERIOD(14)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .fast_clk  (fast_clk),
        .bank      (bank),
        .addr      (addr),
        .dout      (dout),
        .we        (we),
        .IO        (IO),
        .shadow    (shadow),
        .slow_busy (slow_busy),
        .slow_addr (slow_addr),
        .slow_data (slow_data),
        .slow_we   (slow_we),
        .cpu_wait  (cpu_wait),
        .level     (level),
        .overflow  (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk_sys);
        if (reset) ecount = 0;
        else ecount++;
        #1;
    endtask

    task automatic idle_bus();
        fast_clk = 1'b0;
        we = 1'b0;
        IO = 1'b0;
    endtask

    task automatic drive_write(input logic [7:0] b, input logic [15:0] a, input logic [7:0] d);
        fast_clk = 1'b1;
        we = 1'b1;
        IO = 1'b0;
        bank = b;
        addr = a;
        dout = d;
    endtask

    task automatic do_reset();
        idle_bus();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_we(input int max_cycles, output int at_edge);
        at_edge = -1;
        for (int i = 0; i < max_cycles; i++) begin
            step();
            if (slow_we === 1'b1) begin
                at_edge = ecount;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks += 6;
        if (slow_addr !== 17'h0) begin failures++; $display("[TB] FAIL reset_slow_addr: got %h expected 00000", slow_addr); end
        if (slow_data !== 8'h0) begin failures++; $display("[TB] FAIL reset_slow_data: got %h expected 00", slow_data); end
        if (slow_we !== 1'b0) begin failures++; $display("[TB] FAIL reset_slow_we: got %b expected 0", slow_we); end
        if (cpu_wait !== 1'b0) begin failures++; $display("[TB] FAIL reset_cpu_wait: got %b expected 0", cpu_wait); end
        if (level !== 3'd0) begin failures++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
        if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
        reset = 1'b0;
    endtask

    task automatic test_single_write();
        int at;
        do_reset();
        shadow = 8'h00;
        slow_busy = 1'b0;
        drive_write(8'h00, 16'h0400, 8'h41);
        step();
        idle_bus();
        checks++;
        if (level !== 3'd1) begin failures++; $display("[TB] FAIL single_level: got %0d expected 1", level); end
        wait_we(20, at);
        checks += 3;
        if (at != 15) begin failures++; $display("[TB] FAIL single_we_edge: got %0d expected 15", at); end
        if (slow_addr !== 17'h00400) begin failures++; $display("[TB] FAIL single_addr: got %h expected 00400", slow_addr); end
        if (slow_data !== 8'h41) begin failures++; $display("[TB] FAIL single_data: got %h expected 41", slow_data); end
        step();
        checks += 2;
        if (slow_we !== 1'b0) begin failures++; $display("[TB] FAIL single_we_width: got %b expected 0", slow_we); end
        if (level !== 3'd0) begin failures++; $display("[TB] FAIL single_drained: got %0d expected 0", level); end
    endtask

    task automatic probe(input string name, input logic [7:0] b, input logic [15:0] a,
                         input logic [7:0] sh, input logic io, input logic fc, input logic exp);
        do_reset();
        slow_busy = 1'b1;
        shadow = sh;
        drive_write(b, a, 8'hA5);
        IO = io;
        fast_clk = fc;
        step();
        idle_bus();
        checks++;
        if (level !== {2'b00, exp}) begin
            failures++;
            $display("[TB] FAIL decode_%s: level got %0d expected %0d", name, level, exp);
        end
        slow_busy = 1'b0;
    endtask

    task automatic test_decode();
        probe("txt1_hit",     8'h00, 16'h0400, 8'h00, 1'b0, 1'b1, 1'b1);
        probe("txt1_off",     8'h00, 16'h0400, 8'h01, 1'b0, 1'b1, 1'b0);
        probe("txt1_aux_off", 8'h01, 16'h0400, 8'h10, 1'b0, 1'b1, 1'b0);
        probe("txt1_b1_top",  8'h01, 16'h07FF, 8'h00, 1'b0, 1'b1, 1'b1);
        probe("txt2_off",     8'h00, 16'h0800, 8'h20, 1'b0, 1'b1, 1'b0);
        probe("txt2_top",     8'h00, 16'h0BFF, 8'h00, 1'b0, 1'b1, 1'b1);
        probe("gap_0c00",     8'h00, 16'h0C00, 8'h00, 1'b0, 1'b1, 1'b0);
        probe("hgr2_top",     8'h00, 16'h5FFF, 8'h02, 1'b0, 1'b1, 1'b1);
        probe("hgr1_off",     8'h00, 16'h3FFF, 8'h0A, 1'b0, 1'b1, 1'b0);
        probe("hgr2_b1",      8'h01, 16'h4000, 8'h00, 1'b0, 1'b1, 1'b1);
        probe("aux_hgr1",     8'h01, 16'h2000, 8'h10, 1'b0, 1'b1, SHR_BUILD);
        probe("shr_hi",       8'h01, 16'h8000, 8'hF7, 1'b0, 1'b1, SHR_BUILD);
        probe("bank02",       8'h02, 16'h0400, 8'h00, 1'b0, 1'b1, 1'b0);
        probe("io_space",     8'h00, 16'h0400, 8'h00, 1'b1, 1'b1, 1'b0);
        probe("no_strobe",    8'h00, 16'h0400, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_aux();
        int at;
        do_reset();
        shadow = 8'h10;
        slow_busy = 1'b0;
        drive_write(8'h00, 16'h2000, 8'h77);
        step();
        idle_bus();
        wait_we(20, at);
        checks += 3;
        if (at != 15) begin failures++; $display("[TB] FAIL aux_we_edge: got %0d expected 15", at); end
        if (slow_addr !== 17'h02000) begin failures++; $display("[TB] FAIL aux_addr: got %h expected 02000", slow_addr); end
        if (slow_data !== 8'h77) begin failures++; $display("[TB] FAIL aux_data: got %h expected 77", slow_data); end
    endtask

    task automatic test_back_to_back();
        int at;
        int extra;
        do_reset();
        shadow = 8'h00;
        slow_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_write(8'h00, 16'h0400 + 16'(i), 8'h10 + 8'(i));
            step();
            if (i == 2) begin
                checks++;
                if (cpu_wait !== 1'b0) begin failures++; $display("[TB] FAIL b2b_wait_early: got %b expected 0", cpu_wait); end
            end
        end
        checks += 3;
        if (level !== 3'd4) begin failures++; $display("[TB] FAIL b2b_level_full: got %0d expected 4", level); end
        if (cpu_wait !== 1'b1) begin failures++; $display("[TB] FAIL b2b_wait_full: got %b expected 1", cpu_wait); end
        if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL b2b_no_overflow: got %b expected 0", overflow); end
        drive_write(8'h00, 16'h0404, 8'h14);
        step();
        idle_bus();
        checks += 2;
        if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL b2b_overflow: got %b expected 1", overflow); end
        if (level !== 3'd4) begin failures++; $display("[TB] FAIL b2b_level_drop: got %0d expected 4", level); end
        slow_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_we(20, at);
            checks += 3;
            if (at != 15 + 14 * i) begin failures++; $display("[TB] FAIL b2b_edge%0d: got %0d expected %0d", i, at, 15 + 14 * i); end
            if (slow_addr !== 17'h00400 + 17'(i)) begin failures++; $display("[TB] FAIL b2b_addr%0d: got %h expected %h", i, slow_addr, 17'h00400 + 17'(i)); end
            if (slow_data !== 8'h10 + 8'(i)) begin failures++; $display("[TB] FAIL b2b_data%0d: got %h expected %h", i, slow_data, 8'h10 + 8'(i)); end
            if (i == 0) begin
                checks += 2;
                if (cpu_wait !== 1'b0) begin failures++; $display("[TB] FAIL b2b_wait_fall: got %b expected 0", cpu_wait); end
                if (level !== 3'd3) begin failures++; $display("[TB] FAIL b2b_level_pop: got %0d expected 3", level); end
            end
        end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (slow_we === 1'b1) extra++;
        end
        checks += 2;
        if (extra != 0) begin failures++; $display("[TB] FAIL b2b_dropped_written: got %0d writes expected 0", extra); end
        if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL b2b_overflow_sticky: got %b expected 1", overflow); end
        do_reset();
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL b2b_overflow_clear: got %b expected 0", overflow); end
    endtask

    task automatic test_simultaneous();
        int at;
        do_reset();
        shadow = 8'h00;
        slow_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_write(8'h00, 16'h0500 + 16'(i), 8'h20 + 8'(i));
            step();
        end
        idle_bus();
        while (ecount < 14) step();
        slow_busy = 1'b0;
        drive_write(8'h00, 16'h0504, 8'h24);
        step();
        idle_bus();
        checks += 5;
        if (slow_we !== 1'b1) begin failures++; $display("[TB] FAIL sim_we: got %b expected 1", slow_we); end
        if (slow_data !== 8'h20) begin failures++; $display("[TB] FAIL sim_data: got %h expected 20", slow_data); end
        if (level !== 3'd4) begin failures++; $display("[TB] FAIL sim_level: got %0d expected 4", level); end
        if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL sim_overflow: got %b expected 0", overflow); end
        if (cpu_wait !== 1'b1) begin failures++; $display("[TB] FAIL sim_wait: got %b expected 1", cpu_wait); end
        for (int i = 1; i < 5; i++) begin
            wait_we(20, at);
            checks += 2;
            if (at != 15 + 14 * i) begin failures++; $display("[TB] FAIL sim_edge%0d: got %0d expected %0d", i, at, 15 + 14 * i); end
            if (slow_data !== 8'h20 + 8'(i)) begin failures++; $display("[TB] FAIL sim_data%0d: got %h expected %h", i, slow_data, 8'h20 + 8'(i)); end
        end
    endtask

    task automatic test_busy_skip();
        int at;
        int seen;
        do_reset();
        shadow = 8'h00;
        slow_busy = 1'b1;
        drive_write(8'h00, 16'h0400, 8'h30);
        step();
        drive_write(8'h00, 16'h0400, 8'h31);
        step();
        idle_bus();
        seen = 0;
        while (ecount < 43) begin
            step();
            if (slow_we === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin failures++; $display("[TB] FAIL busy_no_write: got %0d writes expected 0", seen); end
        slow_busy = 1'b0;
        wait_we(20, at);
        checks += 2;
        if (at != 57) begin failures++; $display("[TB] FAIL busy_edge0: got %0d expected 57", at); end
        if (slow_data !== 8'h30) begin failures++; $display("[TB] FAIL busy_data0: got %h expected 30", slow_data); end
        wait_we(20, at);
        checks += 3;
        if (at != 71) begin failures++; $display("[TB] FAIL busy_edge1: got %0d expected 71", at); end
        if (slow_data !== 8'h31) begin failures++; $display("[TB] FAIL busy_data1: got %h expected 31", slow_data); end
        if (slow_addr !== 17'h00400) begin failures++; $display("[TB] FAIL busy_addr1: got %h expected 00400", slow_addr); end
    endtask

    task automatic test_reset_mid();
        int seen;
        do_reset();
        shadow = 8'h00;
        slow_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_write(8'h01, 16'h0400 + 16'(i), 8'h60 + 8'(i));
            step();
        end
        idle_bus();
        checks++;
        if (level !== 3'd3) begin failures++; $display("[TB] FAIL rst_mid_queued: got %0d expected 3", level); end
        while (ecount < 14) step();
        slow_busy = 1'b0;
        reset = 1'b1;
        step();
        checks += 3;
        if (level !== 3'd0) begin failures++; $display("[TB] FAIL rst_mid_level: got %0d expected 0", level); end
        if (slow_we !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_we: got %b expected 0", slow_we); end
        if (slow_addr !== 17'h0) begin failures++; $display("[TB] FAIL rst_mid_addr: got %h expected 00000", slow_addr); end
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (slow_we === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin failures++; $display("[TB] FAIL rst_mid_stale: got %0d writes expected 0", seen); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_decode();
        test_aux();
        test_back_to_back();
        test_simultaneous();
        test_busy_skip();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
